// File: rtl/i2c_slave_responder.sv
// I2C target that answers one 7-bit address and serves a small register file.
// SCL/SDA are oversampled on pclk. The master can write a register pointer
// followed by data bytes, and can read bytes back starting at the pointer.
module i2c_slave_responder #(
  parameter logic [6:0]  SLAVE_ADDRESS          = 7'h50,
  parameter int unsigned DATA_LENGTH            = 8,
  parameter int unsigned REGISTER_ADDRESS_WIDTH = 8,
  parameter int unsigned NO_OF_REGS             = 16
) (
  input  logic                              pclk,
  input  logic                              areset,
  input  logic                              scl_i,
  input  logic                              sda_i,
  output logic                              sda_oe,
  output logic                              busy,
  output logic                              wr_strobe,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] wr_reg_addr,
  output logic [DATA_LENGTH-1:0]            wr_data,
  output logic                              rd_strobe
);

  localparam int unsigned PTR_W = (NO_OF_REGS > 1) ? $clog2(NO_OF_REGS) : 1;
  localparam int unsigned SR_A  = (DATA_LENGTH > 8) ? DATA_LENGTH : 8;
  localparam int unsigned SR_W  = (REGISTER_ADDRESS_WIDTH > SR_A) ? REGISTER_ADDRESS_WIDTH : SR_A;
  localparam int unsigned CNT_W = $clog2(SR_W + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG_ADDR, REG_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK, IDLE_WAIT
  } state_t;

  state_t state, state_nxt;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [SR_W-1:0]        shift, shift_nxt, shift_in;
  logic [PTR_W-1:0]       ptr, ptr_nxt, ptr_inc;
  logic [DATA_LENGTH-1:0] tx, tx_nxt;
  logic                   rw, rw_nxt;
  logic                   ack_on, ack_on_nxt;
  logic                   oe_nxt, busy_nxt, wr_stb_nxt, rd_stb_nxt;
  logic [REGISTER_ADDRESS_WIDTH-1:0] wa_nxt;
  logic [DATA_LENGTH-1:0] wd_nxt;
  logic                   reg_we;
  logic [DATA_LENGTH-1:0] rd_byte, rd_next;

  logic [DATA_LENGTH-1:0] regs [NO_OF_REGS];

  // Two-flop synchronizers plus one edge-history flop per bus line.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= scl_i;  scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= sda_i;  sda_s2 <= sda_s1; sda_d <= sda_s2;
    end
  end

  assign scl_rise  =  scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 &  scl_d;
  assign start_det =  scl_s2 &  scl_d & sda_d & ~sda_s2;
  assign stop_det  =  scl_s2 &  scl_d & ~sda_d & sda_s2;

  assign shift_in = {shift[SR_W-2:0], sda_s2};
  assign ptr_inc  = ptr + PTR_W'(1);
  assign rd_byte  = regs[ptr];
  assign rd_next  = regs[ptr_inc];

  // FSM state and datapath registers.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      state       <= IDLE;
      cnt         <= '0;
      shift       <= '0;
      ptr         <= '0;
      tx          <= '0;
      rw          <= 1'b0;
      ack_on      <= 1'b0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      wr_strobe   <= 1'b0;
      rd_strobe   <= 1'b0;
      wr_reg_addr <= '0;
      wr_data     <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      shift       <= shift_nxt;
      ptr         <= ptr_nxt;
      tx          <= tx_nxt;
      rw          <= rw_nxt;
      ack_on      <= ack_on_nxt;
      sda_oe      <= oe_nxt;
      busy        <= busy_nxt;
      wr_strobe   <= wr_stb_nxt;
      rd_strobe   <= rd_stb_nxt;
      wr_reg_addr <= wa_nxt;
      wr_data     <= wd_nxt;
    end
  end

  // Register file, written once per completed data byte.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      for (int unsigned i = 0; i < NO_OF_REGS; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[ptr] <= shift_in[DATA_LENGTH-1:0];
    end
  end

  // Next-state logic: STOP beats START beats SCL-driven protocol progress.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    shift_nxt  = shift;
    ptr_nxt    = ptr;
    tx_nxt     = tx;
    rw_nxt     = rw;
    ack_on_nxt = ack_on;
    oe_nxt     = sda_oe;
    busy_nxt   = busy;
    wr_stb_nxt = 1'b0;
    rd_stb_nxt = 1'b0;
    wa_nxt     = wr_reg_addr;
    wd_nxt     = wr_data;
    reg_we     = 1'b0;

    if (stop_det) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      ack_on_nxt = 1'b0;
      oe_nxt     = 1'b0;
      busy_nxt   = 1'b0;
    end else if (start_det) begin
      state_nxt  = ADDR;
      cnt_nxt    = '0;
      ack_on_nxt = 1'b0;
      oe_nxt     = 1'b0;
      busy_nxt   = 1'b1;
    end else begin
      unique case (state)
        IDLE, IDLE_WAIT: ;

        ADDR: begin
          if (scl_rise) begin
            shift_nxt = shift_in;
            cnt_nxt   = cnt + CNT_W'(1);
            if (cnt == CNT_W'(7)) begin
              cnt_nxt = '0;
              if (shift_in[7:1] == SLAVE_ADDRESS) begin
                state_nxt = ADDR_ACK;
                rw_nxt    = shift_in[0];
              end else begin
                state_nxt = IDLE;
                oe_nxt    = 1'b0;
              end
            end
          end
        end

        // The first fall after the byte starts the ACK, the second ends it.
        // On a read the ending fall also presents the first data bit, which is
        // why the byte is preshifted by one position when loaded here.
        ADDR_ACK, REG_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!ack_on) begin
              oe_nxt     = 1'b1;
              ack_on_nxt = 1'b1;
            end else begin
              ack_on_nxt = 1'b0;
              oe_nxt     = 1'b0;
              cnt_nxt    = '0;
              if (state == ADDR_ACK && rw) begin
                state_nxt  = RD_DATA;
                oe_nxt     = ~rd_byte[DATA_LENGTH-1];
                tx_nxt     = {rd_byte[DATA_LENGTH-2:0], 1'b0};
                rd_stb_nxt = 1'b1;
              end else if (state == ADDR_ACK) begin
                state_nxt = REG_ADDR;
              end else begin
                state_nxt = WR_DATA;
              end
            end
          end
        end

        REG_ADDR: begin
          if (scl_rise) begin
            shift_nxt = shift_in;
            cnt_nxt   = cnt + CNT_W'(1);
            if (cnt == CNT_W'(REGISTER_ADDRESS_WIDTH - 1)) begin
              cnt_nxt   = '0;
              ptr_nxt   = shift_in[PTR_W-1:0];
              state_nxt = REG_ACK;
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            shift_nxt = shift_in;
            cnt_nxt   = cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_LENGTH - 1)) begin
              cnt_nxt    = '0;
              reg_we     = 1'b1;
              wr_stb_nxt = 1'b1;
              wa_nxt     = REGISTER_ADDRESS_WIDTH'(ptr);
              wd_nxt     = shift_in[DATA_LENGTH-1:0];
              ptr_nxt    = ptr_inc;
              state_nxt  = WR_ACK;
            end
          end
        end

        RD_DATA: begin
          if (scl_rise) begin
            cnt_nxt = cnt + CNT_W'(1);
          end else if (scl_fall) begin
            if (cnt < CNT_W'(DATA_LENGTH)) begin
              oe_nxt = ~tx[DATA_LENGTH-1];
              tx_nxt = {tx[DATA_LENGTH-2:0], 1'b0};
            end else begin
              oe_nxt    = 1'b0;
              cnt_nxt   = '0;
              state_nxt = RD_ACK;
            end
          end
        end

        // Next byte is loaded unshifted; RD_DATA drives its MSB on the next fall.
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s2) begin
              ptr_nxt    = ptr_inc;
              tx_nxt     = rd_next;
              rd_stb_nxt = 1'b1;
              cnt_nxt    = '0;
              state_nxt  = RD_DATA;
            end else begin
              oe_nxt    = 1'b0;
              state_nxt = IDLE_WAIT;
            end
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a bus-level I2C master plus a register-file
// model of the target, directed scenarios followed by random transactions.
module tb_i2c_slave_responder;

  localparam int Q = 100;   // quarter SCL period (10 pclk)

  logic       pclk = 1'b0;
  logic       areset = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_i;
  logic       sda_oe, busy, wr_strobe, rd_strobe;
  logic [7:0] wr_reg_addr, wr_data;

  // Open-drain wired-AND of master and target.
  assign sda_i = m_sda & ~sda_oe;

  always #5 pclk = ~pclk;

  i2c_slave_responder #(
    .SLAVE_ADDRESS(7'h50),
    .DATA_LENGTH(8),
    .REGISTER_ADDRESS_WIDTH(8),
    .NO_OF_REGS(16)
  ) dut (
    .pclk(pclk), .areset(areset), .scl_i(scl), .sda_i(sda_i),
    .sda_oe(sda_oe), .busy(busy), .wr_strobe(wr_strobe),
    .wr_reg_addr(wr_reg_addr), .wr_data(wr_data), .rd_strobe(rd_strobe)
  );

  // Strobe/drive monitors, sampled on the falling pclk edge.
  logic [15:0] wr_log [$];
  int          rd_cnt = 0;
  int          oe_cycles = 0;
  always @(negedge pclk) begin
    if (wr_strobe) wr_log.push_back({wr_reg_addr, wr_data});
    if (rd_strobe) rd_cnt++;
    if (sda_oe)    oe_cycles++;
  end

  // Reference model of the target's visible state.
  logic [7:0]  mregs [16];
  int          mptr = 0;
  logic [15:0] exp_wr [$];
  int          wr_chk = 0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      m_sda = 1'b1; #Q; scl = 1'b1; #Q;
    end
    m_sda = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; #Q; scl = 1'b1; #Q; m_sda = 1'b1; #Q;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      m_sda = b[7-i]; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    m_sda = 1'b1; #Q; scl = 1'b1; #Q;
    ack = (sda_i == 1'b0);
    #Q; scl = 1'b0; #Q;
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl = 1'b1; #Q; b[i] = sda_i; #Q; scl = 1'b0; #Q;
    end
    m_sda = master_ack ? 1'b0 : 1'b1;
    #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    m_sda = 1'b1;
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, wr_log.size(), exp_wr.size());
    for (int i = wr_chk; i < exp_wr.size() && i < wr_log.size(); i++)
      chk(tag, wr_log[i], exp_wr[i]);
    wr_chk = exp_wr.size();
  endtask

  task automatic do_write(input logic [7:0] r, input logic [7:0] d [4], input int n);
    logic ack;
    bus_start();
    send_byte(8'hA0, ack); chk("wr_addr_ack", ack, 1'b1);
    send_byte(r, ack);     chk("reg_addr_ack", ack, 1'b1);
    mptr = r % 16;
    for (int i = 0; i < n; i++) begin
      send_byte(d[i], ack); chk("data_ack", ack, 1'b1);
      exp_wr.push_back({8'(mptr), d[i]});
      mregs[mptr] = d[i];
      mptr = (mptr + 1) % 16;
    end
    chk("busy_before_stop", busy, 1'b1);
    bus_stop();
    #60;
    chk("busy_after_stop", busy, 1'b0);
    check_writes("wr_entry");
  endtask

  task automatic do_read(input logic set_ptr, input logic [7:0] r, input int n);
    logic       ack;
    logic [7:0] b;
    int         r0;
    r0 = rd_cnt;
    bus_start();
    if (set_ptr) begin
      send_byte(8'hA0, ack); chk("rd_wr_addr_ack", ack, 1'b1);
      send_byte(r, ack);     chk("rd_reg_addr_ack", ack, 1'b1);
      mptr = r % 16;
      bus_start();
    end
    send_byte(8'hA1, ack); chk("rd_addr_ack", ack, 1'b1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i < n - 1, b);
      chk("rd_byte", b, mregs[(mptr + i) % 16]);
    end
    chk("rel_after_nack", sda_oe, 1'b0);
    chk("rd_strobes", rd_cnt - r0, n);
    mptr = (mptr + n - 1) % 16;
    bus_stop();
    #60;
  endtask

  initial begin
    logic       ack;
    logic [7:0] d [4];
    int         oe0, r0, w0;

    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;

    // Reset values
    #37;
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_strobe", wr_strobe, 1'b0);
    chk("rst_rd_strobe", rd_strobe, 1'b0);
    chk("rst_wr_reg_addr", wr_reg_addr, 8'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    areset = 1'b1;
    #(4*Q);

    // Single register write
    do_write(8'h03, '{8'h5A, 8'h00, 8'h00, 8'h00}, 1);

    // Burst write wrapping the pointer from 0x0F to 0x00, then read regs[0]
    do_write(8'h0F, '{8'h11, 8'h22, 8'h00, 8'h00}, 2);
    do_read(1'b1, 8'h00, 1);

    // Pointer write, repeated START, two-byte read (ACK then NACK)
    do_write(8'h02, '{8'($urandom), 8'($urandom), 8'h00, 8'h00}, 2);
    do_read(1'b1, 8'h02, 2);

    // Foreign address is ignored entirely, then our address is ACKed again
    oe0 = oe_cycles; r0 = rd_cnt; w0 = wr_log.size();
    bus_start();
    send_byte(8'hA2, ack); chk("foreign_nack", ack, 1'b0);
    send_bits(8'h07, 8);
    #(4*Q);
    bus_stop();
    #60;
    chk("foreign_no_drive", oe_cycles - oe0, 0);
    chk("foreign_no_rd", rd_cnt - r0, 0);
    chk("foreign_no_wr", wr_log.size() - w0, 0);
    do_write(8'h07, '{8'hC3, 8'h00, 8'h00, 8'h00}, 1);

    // STOP after a partial data byte writes nothing
    w0 = wr_log.size();
    bus_start();
    send_byte(8'hA0, ack); chk("part_addr_ack", ack, 1'b1);
    send_byte(8'h05, ack); chk("part_reg_ack", ack, 1'b1);
    mptr = 5;
    send_bits(8'hF0, 4);
    bus_stop();
    #60;
    chk("part_no_wr", wr_log.size() - w0, 0);
    chk("part_sda_oe", sda_oe, 1'b0);
    chk("part_busy", busy, 1'b0);
    do_read(1'b1, 8'h05, 1);

    // Reset asserted while the address ACK is being driven
    bus_start();
    send_bits(8'hA0, 8);
    chk("ack_driving", sda_oe, 1'b1);
    areset = 1'b0;
    #1;
    chk("arst_sda_oe", sda_oe, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_wr_strobe", wr_strobe, 1'b0);
    chk("arst_rd_strobe", rd_strobe, 1'b0);
    chk("arst_wr_reg_addr", wr_reg_addr, 8'h00);
    chk("arst_wr_data", wr_data, 8'h00);
    m_sda = 1'b1; #Q; scl = 1'b1; #Q;
    areset = 1'b1;
    #(2*Q);
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = 0;
    do_read(1'b0, 8'h00, 2);

    // Random transactions against the model
    for (int t = 0; t < 10; t++) begin
      int n;
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      case ($urandom_range(0, 2))
        0: do_write(8'($urandom), d, n);
        1: do_read(1'b1, 8'($urandom), n);
        default: do_read(1'b0, 8'h00, n);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
